// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the 5-stage pipeline hazard/forwarding controller.
//   - FWD_* : EX operand select encodings
//   - HZ_*  : last-cycle cause encodings (exposed as hz_state)
//   - slot_t: one scoreboard entry {valid, rw, load}
//   - fwd_sel(): per-operand forwarding select from the EX/MEM slots
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int HZ_REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from EX/MEM ALUout
  localparam logic [1:0] FWD_WR  = 2'b10;  // operand from WR RegDin

  localparam logic [1:0] HZ_RUN   = 2'b00;
  localparam logic [1:0] HZ_STALL = 2'b01;
  localparam logic [1:0] HZ_FLUSH = 2'b10;

  typedef struct packed {
    logic                 valid;  // writes a nonzero register
    logic [HZ_REG_AW-1:0] rw;     // destination register
    logic                 load;   // result only available after MEM
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // Evaluated while the consumer sits in ID: the current EX slot will be in
  // EX/MEM and the current MEM slot in WR when the consumer reaches EX.
  // A matching load in EX is never forwarded; the load-use stall covers it.
  function automatic logic [1:0] fwd_sel(input logic                 use_r,
                                         input logic [HZ_REG_AW-1:0] r,
                                         input slot_t                ex,
                                         input slot_t                mem);
    fwd_sel = FWD_RF;
    if (use_r && (r != '0)) begin
      if (ex.valid && !ex.load && (ex.rw == r)) begin
        fwd_sel = FWD_MEM;
      end else if (mem.valid && (mem.rw == r)) begin
        fwd_sel = FWD_WR;
      end
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   master drives: hz_en, id_rs, id_rt, id_use_rs, id_use_rt, id_rw,
//                  id_reg_wr, id_load, mem_pc_src
//   slave drives : pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush,
//                  fwd_a, fwd_b, hz_state, stall_cnt, flush_cnt,
//                  dbg_ex, dbg_mem, dbg_wr (scoreboard slots)
// Handshake: there is no valid/ready pair. Every signal is a level that is
// meaningful in every cycle; the controller samples the ID-stage fields on
// each rising clock edge and its enables/flushes apply to that same edge.
// CNT_W must match the CNT_W of the attached pipe_hazard_ctrl.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int REG_AW = HZ_REG_AW;

  logic              hz_en;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rw;
  logic              id_reg_wr;
  logic              id_load;
  logic              mem_pc_src;

  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        hz_state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  slot_t             dbg_ex;
  slot_t             dbg_mem;
  slot_t             dbg_wr;

  modport master (
    output hz_en, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_reg_wr,
           id_load, mem_pc_src,
    input  pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
           hz_state, stall_cnt, flush_cnt, dbg_ex, dbg_mem, dbg_wr
  );

  modport slave (
    input  hz_en, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_reg_wr,
           id_load, mem_pc_src,
    output pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
           hz_state, stall_cnt, flush_cnt, dbg_ex, dbg_mem, dbg_wr
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hz_sat_counter.sv
// ---------------------------------------------------------------------------
// hz_sat_counter
// Saturating up-counter used for the stall and flush performance counters.
//   i_clk  : clock, rising edge
//   i_clrn : asynchronous active-low reset (clears to 0)
//   i_inc  : count one event this cycle
//   o_cnt  : current count, holds at all-ones
// ---------------------------------------------------------------------------
module hz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clrn,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard/forwarding controller for an IF-ID-EX-MEM-WR pipeline.
// Keeps a shadow scoreboard of in-flight destinations (EX/MEM/WR slots),
// detects load-use stalls and taken-branch redirects, drives PC/IF-ID write
// enables and pipeline flushes, registers EX forwarding selects, and counts
// stall and flush cycles.
//   i_clk  : pipeline clock, rising edge
//   i_clrn : asynchronous active-low reset
//   io_hz  : pipe_hazard_ctrl_if.slave (ID fields in, controls/status out)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clrn,
  pipe_hazard_ctrl_if.slave io_hz
);

  slot_t      r_ex_slot;
  slot_t      r_mem_slot;
  slot_t      r_wr_slot;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic [1:0] r_hz_state;

  slot_t      w_id_slot;
  logic       w_hit_rs;
  logic       w_hit_rt;
  logic       w_lu;
  logic       w_fl;
  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A slot is valid only for a real (nonzero) register write.
  assign w_id_slot = '{valid: io_hz.id_reg_wr && (io_hz.id_rw != '0),
                       rw:    io_hz.id_rw,
                       load:  io_hz.id_load};

  // Load-use: the load in EX has no result until after MEM, so the consumer
  // must wait one cycle in ID. r_ex_slot.valid already excludes $0.
  assign w_hit_rs = io_hz.id_use_rs && (io_hz.id_rs == r_ex_slot.rw);
  assign w_hit_rt = io_hz.id_use_rt && (io_hz.id_rt == r_ex_slot.rw);
  assign w_lu     = io_hz.hz_en && r_ex_slot.valid && r_ex_slot.load &&
                    (w_hit_rs || w_hit_rt);
  assign w_fl     = io_hz.hz_en && io_hz.mem_pc_src;

  // A redirect kills the stalled consumer, so flush wins over stall.
  assign w_stall  = w_lu && !w_fl;

  assign io_hz.pc_we       = !w_stall;
  assign io_hz.ifid_we     = !w_stall;
  assign io_hz.ifid_flush  = w_fl;
  assign io_hz.idex_flush  = w_fl || w_lu;
  assign io_hz.exmem_flush = w_fl;

  assign w_fwd_a = fwd_sel(io_hz.id_use_rs, io_hz.id_rs, r_ex_slot, r_mem_slot);
  assign w_fwd_b = fwd_sel(io_hz.id_use_rt, io_hz.id_rt, r_ex_slot, r_mem_slot);

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_ex_slot  <= SLOT_BUBBLE;
      r_mem_slot <= SLOT_BUBBLE;
      r_wr_slot  <= SLOT_BUBBLE;
      r_fwd_a    <= FWD_RF;
      r_fwd_b    <= FWD_RF;
      r_hz_state <= HZ_RUN;
    end else begin
      r_wr_slot <= r_mem_slot;
      if (w_fl) begin
        // Wrong-path instructions in ID and EX are squashed.
        r_ex_slot  <= SLOT_BUBBLE;
        r_mem_slot <= SLOT_BUBBLE;
        r_hz_state <= HZ_FLUSH;
      end else if (w_lu) begin
        // Bubble into EX while the load advances to MEM.
        r_ex_slot  <= SLOT_BUBBLE;
        r_mem_slot <= r_ex_slot;
        r_hz_state <= HZ_STALL;
      end else begin
        r_ex_slot  <= w_id_slot;
        r_mem_slot <= r_ex_slot;
        r_hz_state <= HZ_RUN;
      end
      // Whenever a bubble enters EX (or handling is off) forwarding is idle.
      if (w_fl || w_lu || !io_hz.hz_en) begin
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end
  end

  assign io_hz.fwd_a    = r_fwd_a;
  assign io_hz.fwd_b    = r_fwd_b;
  assign io_hz.hz_state = r_hz_state;
  assign io_hz.dbg_ex   = r_ex_slot;
  assign io_hz.dbg_mem  = r_mem_slot;
  assign io_hz.dbg_wr   = r_wr_slot;

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk  (i_clk),
    .i_clrn (i_clrn),
    .i_inc  (w_stall),
    .o_cnt  (io_hz.stall_cnt)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk  (i_clk),
    .i_clrn (i_clrn),
    .i_inc  (w_fl),
    .o_cnt  (io_hz.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives instruction sequences into the ID-stage fields of pipe_hazard_ctrl
// and checks the enables/flushes, forwarding selects, cause and counters.
// A small 4-bit hz_sat_counter instance exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) hz_if ();

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .i_clk  (clk),
    .i_clrn (clrn),
    .io_hz  (hz_if.slave)
  );

  logic       sat_inc;
  logic [3:0] sat_cnt;

  hz_sat_counter #(.CNT_W(4)) u_sat (
    .i_clk  (clk),
    .i_clrn (clrn),
    .i_inc  (sat_inc),
    .o_cnt  (sat_cnt)
  );

  // ---------------- scoreboard ----------------
  // {ctl[4:0], fwd_a, fwd_b, hz_state, stall_cnt[15:0], flush_cnt[15:0]}
  logic [42:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_stall = '0;
  logic [15:0] exp_flush = '0;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl_obs();
    return {hz_if.pc_we, hz_if.ifid_we, hz_if.ifid_flush, hz_if.idex_flush,
            hz_if.exmem_flush};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; presents one ID instruction for one
  // cycle. kind is the cause the spec demands for that cycle; fa/fb are the
  // selects the instruction must see once it reaches EX.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt,
                      input logic [4:0] rw, input logic rwr, input logic ld,
                      input logic pcsrc, input logic [1:0] kind,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input string tag);
    logic [4:0]  exp_ctl;
    logic [4:0]  obs_ctl;
    logic [42:0] e;
    hz_if.id_rs      = rs;
    hz_if.id_rt      = rt;
    hz_if.id_use_rs  = urs;
    hz_if.id_use_rt  = urt;
    hz_if.id_rw      = rw;
    hz_if.id_reg_wr  = rwr;
    hz_if.id_load    = ld;
    hz_if.mem_pc_src = pcsrc;
    case (kind)
      HZ_STALL: exp_ctl = 5'b00010;
      HZ_FLUSH: exp_ctl = 5'b11111;
      default:  exp_ctl = 5'b11000;
    endcase
    if (kind == HZ_STALL) exp_stall = exp_stall + 16'd1;
    if (kind == HZ_FLUSH) exp_flush = exp_flush + 16'd1;
    exp_q.push_back({exp_ctl, fa, fb, kind, exp_stall, exp_flush});
    #2;
    obs_ctl = ctl_obs();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_ctl"}, 64'(obs_ctl), 64'(e[42:38]));
    chk({tag, "_fwd"}, 64'({hz_if.fwd_a, hz_if.fwd_b, hz_if.hz_state}),
        64'(e[37:32]));
    chk({tag, "_cnt"}, 64'({hz_if.stall_cnt, hz_if.flush_cnt}), 64'(e[31:0]));
  endtask

  task automatic nop(input string tag);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, HZ_RUN, FWD_RF,
         FWD_RF, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop("nop");
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs,
                     input logic [4:0] rt, input logic pcsrc,
                     input logic [1:0] kind, input logic [1:0] fa,
                     input logic [1:0] fb, input string tag);
    step(rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, pcsrc, kind, fa, fb, tag);
  endtask

  // lw rd, 0($0)
  task automatic lw(input logic [4:0] rd, input string tag);
    step(5'd0, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, HZ_RUN, FWD_RF,
         FWD_RF, tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    hz_if.hz_en      = 1'b1;
    hz_if.id_rs      = '0;
    hz_if.id_rt      = '0;
    hz_if.id_use_rs  = 1'b0;
    hz_if.id_use_rt  = 1'b0;
    hz_if.id_rw      = '0;
    hz_if.id_reg_wr  = 1'b0;
    hz_if.id_load    = 1'b0;
    hz_if.mem_pc_src = 1'b0;
    sat_inc          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'(ctl_obs()), 64'(5'b11000));
    chk("rst_fwd", 64'({hz_if.fwd_a, hz_if.fwd_b, hz_if.hz_state}), 64'(0));
    chk("rst_cnt", 64'({hz_if.stall_cnt, hz_if.flush_cnt}), 64'(0));
    chk("rst_sb", 64'({hz_if.dbg_wr.valid, hz_if.dbg_mem.valid,
                       hz_if.dbg_ex.valid}), 64'(0));
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // 1: back-to-back ALU dependency -> EX/MEM forward on both operands
    alu(5'd1, 5'd2, 5'd3, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t1_prod");
    alu(5'd2, 5'd1, 5'd1, 1'b0, HZ_RUN, FWD_MEM, FWD_MEM, "t1_cons");
    drain();

    // 2: one instruction in between -> WR forward on A only
    alu(5'd1, 5'd7, 5'd8, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t2_prod");
    nop("t2_nop");
    alu(5'd3, 5'd1, 5'd4, 1'b0, HZ_RUN, FWD_WR, FWD_RF, "t2_cons");
    drain();

    // 3: load-use -> one stall, then WR forward
    lw(5'd5, "t3_lw");
    alu(5'd6, 5'd5, 5'd0, 1'b0, HZ_STALL, FWD_RF, FWD_RF, "t3_stall");
    alu(5'd6, 5'd5, 5'd0, 1'b0, HZ_RUN, FWD_WR, FWD_RF, "t3_go");
    drain();

    // Rs=Rt=Rw: still a single stall cycle
    lw(5'd7, "t3b_lw");
    alu(5'd8, 5'd7, 5'd7, 1'b0, HZ_STALL, FWD_RF, FWD_RF, "t3b_stall");
    alu(5'd8, 5'd7, 5'd7, 1'b0, HZ_RUN, FWD_WR, FWD_WR, "t3b_go");
    drain();

    // 4: redirect -> all flushes, EX/MEM slots cleared, WR keeps old MEM
    alu(5'd1, 5'd2, 5'd3, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t4_a");
    alu(5'd2, 5'd4, 5'd5, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t4_b");
    alu(5'd3, 5'd1, 5'd2, 1'b1, HZ_FLUSH, FWD_RF, FWD_RF, "t4_fl");
    chk("t4_sb", 64'({hz_if.dbg_wr.valid, hz_if.dbg_mem.valid,
                      hz_if.dbg_ex.valid}), 64'(3'b100));
    chk("t4_wr_rw", 64'(hz_if.dbg_wr.rw), 64'(5'd1));
    alu(5'd3, 5'd1, 5'd2, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t4_after");
    drain();

    // 5: load-use coincident with redirect -> flush only
    lw(5'd5, "t5_lw");
    alu(5'd6, 5'd5, 5'd5, 1'b1, HZ_FLUSH, FWD_RF, FWD_RF, "t5_both");
    drain();

    // counter saturation on a 4-bit instance
    sat_inc = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("sat_14", 64'(sat_cnt), 64'(4'd14));
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold", 64'(sat_cnt), 64'(4'hF));
    sat_inc = 1'b0;

    // 6: handling disabled -> no stall, no flush, no forwarding
    hz_if.hz_en = 1'b0;
    lw(5'd5, "t6_lw");
    alu(5'd6, 5'd5, 5'd0, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t6_use");
    alu(5'd7, 5'd6, 5'd6, 1'b0, HZ_RUN, FWD_RF, FWD_RF, "t6_alu");
    alu(5'd9, 5'd1, 5'd1, 1'b1, HZ_RUN, FWD_RF, FWD_RF, "t6_pcsrc");
    hz_if.hz_en = 1'b1;
    drain();

    // reset asserted while a load-use stall is being signalled
    lw(5'd5, "rs_lw");
    hz_if.id_rs      = 5'd5;
    hz_if.id_rt      = 5'd0;
    hz_if.id_use_rs  = 1'b1;
    hz_if.id_use_rt  = 1'b1;
    hz_if.id_rw      = 5'd6;
    hz_if.id_reg_wr  = 1'b1;
    hz_if.id_load    = 1'b0;
    hz_if.mem_pc_src = 1'b0;
    #2;
    chk("rs_pre_ctl", 64'(ctl_obs()), 64'(5'b00010));
    clrn = 1'b0;
    #1;
    chk("rs_ctl", 64'(ctl_obs()), 64'(5'b11000));
    chk("rs_fwd", 64'({hz_if.fwd_a, hz_if.fwd_b, hz_if.hz_state}), 64'(0));
    chk("rs_cnt", 64'({hz_if.stall_cnt, hz_if.flush_cnt}), 64'(0));
    chk("rs_sb", 64'({hz_if.dbg_wr.valid, hz_if.dbg_mem.valid,
                      hz_if.dbg_ex.valid}), 64'(0));
    exp_stall = '0;
    exp_flush = '0;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    nop("post_rst_nop");
    lw(5'd4, "post_rst_lw");
    alu(5'd6, 5'd0, 5'd4, 1'b0, HZ_STALL, FWD_RF, FWD_RF, "post_rst_stall");
    alu(5'd6, 5'd0, 5'd4, 1'b0, HZ_RUN, FWD_RF, FWD_WR, "post_rst_go");

    chk("q_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
